// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, op bit indices and request type for the ALU arbiter
package alu_pkg;

  localparam int ALU_OP_W  = 12;
  localparam int DATA_W    = 32;
  localparam int N_MASTERS = 2;

  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_SLT  = 2;
  localparam int OP_SLTU = 3;
  localparam int OP_AND  = 4;
  localparam int OP_NOR  = 5;
  localparam int OP_OR   = 6;
  localparam int OP_XOR  = 7;
  localparam int OP_SLL  = 8;
  localparam int OP_SRL  = 9;
  localparam int OP_SRA  = 10;
  localparam int OP_LUI  = 11;

  typedef logic [ALU_OP_W-1:0] alu_op_t;
  typedef logic [DATA_W-1:0]   data_t;

  typedef struct packed {
    alu_op_t op;
    data_t   src1;
    data_t   src2;
  } alu_req_t;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational one-hot ALU; multi-hot ops OR their results together
module alu
  import alu_pkg::*;
(
  input  logic [ALU_OP_W-1:0] op,
  input  logic [DATA_W-1:0]   src1,
  input  logic [DATA_W-1:0]   src2,
  output logic [DATA_W-1:0]   result,
  output logic                overflow
);

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic [DATA_W-1:0] sra_res;
  logic [4:0]        shamt;
  logic              lt_signed;
  logic              lt_unsigned;
  logic              add_ovf;
  logic              sub_ovf;

  assign shamt       = src1[4:0];
  assign sum         = src1 + src2;
  assign diff        = src1 - src2;
  assign sra_res     = $unsigned($signed(src2) >>> shamt);
  assign lt_signed   = $signed(src1) < $signed(src2);
  assign lt_unsigned = src1 < src2;

  // Signed overflow: operands' signs make the true result unrepresentable
  assign add_ovf = (src1[DATA_W-1] == src2[DATA_W-1]) && (sum[DATA_W-1]  != src1[DATA_W-1]);
  assign sub_ovf = (src1[DATA_W-1] != src2[DATA_W-1]) && (diff[DATA_W-1] != src1[DATA_W-1]);

  // Accumulate every selected op's result so op==0 yields zero
  always_comb begin
    result = '0;
    if (op[OP_ADD])  result = result | sum;
    if (op[OP_SUB])  result = result | diff;
    if (op[OP_SLT])  result = result | {{(DATA_W-1){1'b0}}, lt_signed};
    if (op[OP_SLTU]) result = result | {{(DATA_W-1){1'b0}}, lt_unsigned};
    if (op[OP_AND])  result = result | (src1 & src2);
    if (op[OP_NOR])  result = result | ~(src1 | src2);
    if (op[OP_OR])   result = result | (src1 | src2);
    if (op[OP_XOR])  result = result | (src1 ^ src2);
    if (op[OP_SLL])  result = result | (src2 << shamt);
    if (op[OP_SRL])  result = result | (src2 >> shamt);
    if (op[OP_SRA])  result = result | sra_res;
    if (op[OP_LUI])  result = result | {src2[15:0], 16'h0000};
  end

  // Only add/sub can overflow
  always_comb begin
    overflow = (op[OP_ADD] & add_ovf) | (op[OP_SUB] & sub_ovf);
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-master arbiter sharing one ALU with per-master response registers
module alu_arbiter
  import alu_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_req_valid,
  output logic                m0_req_ready,
  input  logic [ALU_OP_W-1:0] m0_req_op,
  input  logic [DATA_W-1:0]   m0_req_src1,
  input  logic [DATA_W-1:0]   m0_req_src2,
  output logic                m0_rsp_valid,
  input  logic                m0_rsp_ready,
  output logic [DATA_W-1:0]   m0_rsp_result,
  output logic                m0_rsp_overflow,
  input  logic                m1_req_valid,
  output logic                m1_req_ready,
  input  logic [ALU_OP_W-1:0] m1_req_op,
  input  logic [DATA_W-1:0]   m1_req_src1,
  input  logic [DATA_W-1:0]   m1_req_src2,
  output logic                m1_rsp_valid,
  input  logic                m1_rsp_ready,
  output logic [DATA_W-1:0]   m1_rsp_result,
  output logic                m1_rsp_overflow
);

  logic [N_MASTERS-1:0]             rsp_valid_q, rsp_valid_d;
  logic [N_MASTERS-1:0][DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic [N_MASTERS-1:0]             rsp_ovf_q, rsp_ovf_d;
  logic                             last_q, last_d;

  logic [N_MASTERS-1:0] req_valid;
  logic [N_MASTERS-1:0] rsp_ready;
  logic [N_MASTERS-1:0] eligible;
  logic [N_MASTERS-1:0] contend;
  logic [N_MASTERS-1:0] req_ready;
  logic [N_MASTERS-1:0] fire;
  logic                 prefer_m0;
  alu_req_t             issue;
  logic [DATA_W-1:0]    alu_result;
  logic                 alu_overflow;

  assign req_valid = {m1_req_valid, m0_req_valid};
  assign rsp_ready = {m1_rsp_ready, m0_rsp_ready};

  // Grant: a master's ready depends only on its own eligibility and on whether the
  // other master is contending with higher priority, never on its own valid
  always_comb begin
    eligible     = ~rsp_valid_q | rsp_ready;
    contend      = req_valid & eligible;
    prefer_m0    = RR_EN ? last_q : 1'b1;
    req_ready    = '0;
    req_ready[0] = ~reset & eligible[0] & (~contend[1] | prefer_m0);
    req_ready[1] = ~reset & eligible[1] & (~contend[0] | ~prefer_m0);
    fire         = req_valid & req_ready;
  end

  // Steer the accepted master's request into the shared ALU
  always_comb begin
    if (fire[1]) begin
      issue = '{op: m1_req_op, src1: m1_req_src1, src2: m1_req_src2};
    end else begin
      issue = '{op: m0_req_op, src1: m0_req_src1, src2: m0_req_src2};
    end
  end

  alu u_alu (
    .op       (issue.op),
    .src1     (issue.src1),
    .src2     (issue.src2),
    .result   (alu_result),
    .overflow (alu_overflow)
  );

  // Response registers load on acceptance, empty on drain; pointer moves only on acceptance
  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_ovf_d    = rsp_ovf_q;
    last_d       = last_q;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (fire[i]) begin
        rsp_valid_d[i]  = 1'b1;
        rsp_result_d[i] = alu_result;
        rsp_ovf_d[i]    = alu_overflow;
        last_d          = 1'(i);
      end else if (rsp_ready[i]) begin
        rsp_valid_d[i]  = 1'b0;
      end
    end
  end

  // State registers; reset favours master 0 on the first contention
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_ovf_q    <= '0;
      last_q       <= 1'b1;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_ovf_q    <= rsp_ovf_d;
      last_q       <= last_d;
    end
  end

  assign m0_req_ready    = req_ready[0];
  assign m1_req_ready    = req_ready[1];
  assign m0_rsp_valid    = rsp_valid_q[0];
  assign m1_rsp_valid    = rsp_valid_q[1];
  assign m0_rsp_result   = rsp_result_q[0];
  assign m1_rsp_result   = rsp_result_q[1];
  assign m0_rsp_overflow = rsp_ovf_q[0];
  assign m1_rsp_overflow = rsp_ovf_q[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter against a behavioural model
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;

  logic        m0_req_valid, m1_req_valid, m0_rsp_ready, m1_rsp_ready;
  logic [11:0] m0_req_op, m1_req_op;
  logic [31:0] m0_req_src1, m0_req_src2, m1_req_src1, m1_req_src2;
  logic        m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid;
  logic [31:0] m0_rsp_result, m1_rsp_result;
  logic        m0_rsp_overflow, m1_rsp_overflow;

  logic        f_m0_req_valid, f_m1_req_valid, f_m0_rsp_ready, f_m1_rsp_ready;
  logic        f_m0_req_ready, f_m1_req_ready, f_m0_rsp_valid, f_m1_rsp_valid;
  logic [31:0] f_m0_rsp_result, f_m1_rsp_result;
  logic        f_m0_rsp_overflow, f_m1_rsp_overflow;

  int n_assert = 0;
  int n_fail   = 0;

  logic        mv   [2];
  logic [31:0] mres [2];
  logic        movf [2];
  int          mlast;

  always #5 clk = ~clk;

  alu_arbiter #(.RR_EN(1'b1)) dut (
    .clk(clk), .reset(reset),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_op(m0_req_op),
    .m0_req_src1(m0_req_src1), .m0_req_src2(m0_req_src2),
    .m0_rsp_valid(m0_rsp_valid), .m0_rsp_ready(m0_rsp_ready),
    .m0_rsp_result(m0_rsp_result), .m0_rsp_overflow(m0_rsp_overflow),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_op(m1_req_op),
    .m1_req_src1(m1_req_src1), .m1_req_src2(m1_req_src2),
    .m1_rsp_valid(m1_rsp_valid), .m1_rsp_ready(m1_rsp_ready),
    .m1_rsp_result(m1_rsp_result), .m1_rsp_overflow(m1_rsp_overflow)
  );

  alu_arbiter #(.RR_EN(1'b0)) dut_fixed (
    .clk(clk), .reset(reset),
    .m0_req_valid(f_m0_req_valid), .m0_req_ready(f_m0_req_ready), .m0_req_op(m0_req_op),
    .m0_req_src1(m0_req_src1), .m0_req_src2(m0_req_src2),
    .m0_rsp_valid(f_m0_rsp_valid), .m0_rsp_ready(f_m0_rsp_ready),
    .m0_rsp_result(f_m0_rsp_result), .m0_rsp_overflow(f_m0_rsp_overflow),
    .m1_req_valid(f_m1_req_valid), .m1_req_ready(f_m1_req_ready), .m1_req_op(m1_req_op),
    .m1_req_src1(m1_req_src1), .m1_req_src2(m1_req_src2),
    .m1_rsp_valid(f_m1_rsp_valid), .m1_rsp_ready(f_m1_rsp_ready),
    .m1_rsp_result(f_m1_rsp_result), .m1_rsp_overflow(f_m1_rsp_overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference ALU from the op definitions, using 64-bit signed arithmetic
  task automatic ref_alu(input logic [11:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic o);
    longint sa, sb, s;
    logic [63:0] w;
    sa = $signed(a);
    sb = $signed(b);
    r = 32'h0;
    o = 1'b0;
    if (op[0]) begin
      s = sa + sb; w = s; r = r | w[31:0];
      if (s > 64'sd2147483647 || s < -64'sd2147483648) o = 1'b1;
    end
    if (op[1]) begin
      s = sa - sb; w = s; r = r | w[31:0];
      if (s > 64'sd2147483647 || s < -64'sd2147483648) o = 1'b1;
    end
    if (op[2])  r = r | ((sa < sb) ? 32'd1 : 32'd0);
    if (op[3])  r = r | ((a < b) ? 32'd1 : 32'd0);
    if (op[4])  r = r | (a & b);
    if (op[5])  r = r | ~(a | b);
    if (op[6])  r = r | (a | b);
    if (op[7])  r = r | (a ^ b);
    if (op[8])  r = r | (b << a[4:0]);
    if (op[9])  r = r | (b >> a[4:0]);
    if (op[10]) begin s = sb >>> a[4:0]; w = s; r = r | w[31:0]; end
    if (op[11]) r = r | (b[15:0] * 32'd65536);
  endtask

  // Expected readies: master i may be accepted if its slot frees up and it would win
  task automatic predict(output logic er0, output logic er1);
    logic e0, e1, c0, c1;
    int tie_winner;
    e0 = !mv[0] || m0_rsp_ready;
    e1 = !mv[1] || m1_rsp_ready;
    c0 = m0_req_valid && e0;
    c1 = m1_req_valid && e1;
    tie_winner = (mlast == 0) ? 1 : 0;
    er0 = !reset && e0 && (!c1 || tie_winner == 0);
    er1 = !reset && e1 && (!c0 || tie_winner == 1);
  endtask

  // One clock: check outputs mid-cycle, then advance the model at the edge
  task automatic cycle(input string tag);
    logic er0, er1, o;
    logic [31:0] r;
    @(negedge clk);
    predict(er0, er1);
    chk({tag, "_m0_req_ready"}, {31'b0, m0_req_ready}, {31'b0, er0});
    chk({tag, "_m1_req_ready"}, {31'b0, m1_req_ready}, {31'b0, er1});
    chk({tag, "_m0_rsp_valid"}, {31'b0, m0_rsp_valid}, {31'b0, mv[0]});
    chk({tag, "_m1_rsp_valid"}, {31'b0, m1_rsp_valid}, {31'b0, mv[1]});
    if (mv[0]) begin
      chk({tag, "_m0_result"}, m0_rsp_result, mres[0]);
      chk({tag, "_m0_ovf"}, {31'b0, m0_rsp_overflow}, {31'b0, movf[0]});
    end
    if (mv[1]) begin
      chk({tag, "_m1_result"}, m1_rsp_result, mres[1]);
      chk({tag, "_m1_ovf"}, {31'b0, m1_rsp_overflow}, {31'b0, movf[1]});
    end
    @(posedge clk);
    if (m0_req_valid && er0) begin
      ref_alu(m0_req_op, m0_req_src1, m0_req_src2, r, o);
      mv[0] = 1'b1; mres[0] = r; movf[0] = o; mlast = 0;
    end else if (m0_rsp_ready) begin
      mv[0] = 1'b0;
    end
    if (m1_req_valid && er1) begin
      ref_alu(m1_req_op, m1_req_src1, m1_req_src2, r, o);
      mv[1] = 1'b1; mres[1] = r; movf[1] = o; mlast = 1;
    end else if (m1_rsp_ready) begin
      mv[1] = 1'b0;
    end
    #1;
  endtask

  // Asynchronous reset: outputs must clear before any clock edge
  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    chk({tag, "_m0_rsp_valid"}, {31'b0, m0_rsp_valid}, 32'd0);
    chk({tag, "_m1_rsp_valid"}, {31'b0, m1_rsp_valid}, 32'd0);
    chk({tag, "_m0_result"}, m0_rsp_result, 32'd0);
    chk({tag, "_m1_result"}, m1_rsp_result, 32'd0);
    chk({tag, "_m0_ovf"}, {31'b0, m0_rsp_overflow}, 32'd0);
    chk({tag, "_m1_ovf"}, {31'b0, m1_rsp_overflow}, 32'd0);
    chk({tag, "_m0_req_ready"}, {31'b0, m0_req_ready}, 32'd0);
    chk({tag, "_m1_req_ready"}, {31'b0, m1_req_ready}, 32'd0);
    mv[0] = 1'b0; mv[1] = 1'b0;
    mres[0] = 32'h0; mres[1] = 32'h0;
    movf[0] = 1'b0; movf[1] = 1'b0;
    mlast = 1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic set_m0(input logic v, input logic [11:0] op, input logic [31:0] a, input logic [31:0] b);
    m0_req_valid = v; m0_req_op = op; m0_req_src1 = a; m0_req_src2 = b;
  endtask

  task automatic set_m1(input logic v, input logic [11:0] op, input logic [31:0] a, input logic [31:0] b);
    m1_req_valid = v; m1_req_op = op; m1_req_src1 = a; m1_req_src2 = b;
  endtask

  function automatic logic [31:0] rnd_data();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [11:0] rnd_op();
    int sel;
    logic [31:0] raw;
    sel = $urandom_range(0, 9);
    raw = $urandom;
    if (sel == 0) return 12'h000;
    if (sel == 1) return raw[11:0];
    return 12'h001 << $urandom_range(0, 11);
  endfunction

  initial begin
    reset = 1'b0;
    set_m0(1'b0, 12'h0, 32'h0, 32'h0);
    set_m1(1'b0, 12'h0, 32'h0, 32'h0);
    m0_rsp_ready = 1'b0; m1_rsp_ready = 1'b0;
    f_m0_req_valid = 1'b0; f_m1_req_valid = 1'b0;
    f_m0_rsp_ready = 1'b0; f_m1_rsp_ready = 1'b0;

    do_reset("rst0");

    // m0 add 7+5
    m0_rsp_ready = 1'b1; m1_rsp_ready = 1'b1;
    set_m0(1'b1, 12'h001, 32'd7, 32'd5);
    cycle("add75");
    chk("add75_valid", {31'b0, m0_rsp_valid}, 32'd1);
    chk("add75_result", m0_rsp_result, 32'd12);
    chk("add75_ovf", {31'b0, m0_rsp_overflow}, 32'd0);
    set_m0(1'b0, 12'h0, 32'h0, 32'h0);

    // m1 overflowing add, then arithmetic shift
    set_m1(1'b1, 12'h001, 32'h7FFF_FFFF, 32'h0000_0001);
    cycle("addovf");
    chk("addovf_result", m1_rsp_result, 32'h8000_0000);
    chk("addovf_ovf", {31'b0, m1_rsp_overflow}, 32'd1);
    set_m1(1'b1, 12'h400, 32'd4, 32'h8000_0000);
    cycle("sra");
    chk("sra_result", m1_rsp_result, 32'hF800_0000);
    chk("sra_ovf", {31'b0, m1_rsp_overflow}, 32'd0);
    set_m1(1'b0, 12'h0, 32'h0, 32'h0);
    cycle("idle0");

    // Continuous contention: round-robin alternates, fixed priority always m0
    do_reset("rst1");
    set_m0(1'b1, 12'h001, 32'd100, 32'd23);
    set_m1(1'b1, 12'h080, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    m0_rsp_ready = 1'b1; m1_rsp_ready = 1'b1;
    f_m0_req_valid = 1'b1; f_m1_req_valid = 1'b1;
    f_m0_rsp_ready = 1'b1; f_m1_rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("rr%0d_m0_gnt", k), {31'b0, m0_req_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("rr%0d_m1_gnt", k), {31'b0, m1_req_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
      chk($sformatf("fp%0d_m0_gnt", k), {31'b0, f_m0_req_ready}, 32'd1);
      chk($sformatf("fp%0d_m1_gnt", k), {31'b0, f_m1_req_ready}, 32'd0);
      cycle($sformatf("rr%0d", k));
    end
    chk("fp_m0_valid", {31'b0, f_m0_rsp_valid}, 32'd1);
    chk("fp_m0_result", f_m0_rsp_result, 32'd123);
    chk("fp_m0_ovf", {31'b0, f_m0_rsp_overflow}, 32'd0);
    chk("fp_m1_valid", {31'b0, f_m1_rsp_valid}, 32'd0);
    chk("fp_m1_result", f_m1_rsp_result, 32'd0);
    chk("fp_m1_ovf", {31'b0, f_m1_rsp_overflow}, 32'd0);
    f_m0_req_valid = 1'b0; f_m1_req_valid = 1'b0;
    set_m0(1'b0, 12'h0, 32'h0, 32'h0);
    set_m1(1'b0, 12'h0, 32'h0, 32'h0);
    cycle("idle1");

    // m0 stalled on its response while m1 keeps issuing
    m0_rsp_ready = 1'b0; m1_rsp_ready = 1'b1;
    set_m0(1'b1, 12'h002, 32'd50, 32'd8);
    cycle("stall_load");
    set_m0(1'b1, 12'h010, 32'hFFFF_0000, 32'h1234_5678);
    for (int k = 0; k < 4; k++) begin
      set_m1(1'b1, 12'h100, 32'(k + 1), 32'h0000_0003);
      #1;
      chk($sformatf("stall%0d_m0_rdy", k), {31'b0, m0_req_ready}, 32'd0);
      chk($sformatf("stall%0d_m1_rdy", k), {31'b0, m1_req_ready}, 32'd1);
      cycle($sformatf("stall%0d", k));
      chk($sformatf("stall%0d_m0_held", k), m0_rsp_result, 32'd42);
    end
    set_m1(1'b0, 12'h0, 32'h0, 32'h0);
    m0_rsp_ready = 1'b1;
    #1;
    chk("drain_m0_rdy", {31'b0, m0_req_ready}, 32'd1);
    cycle("drain");
    chk("drain_m0_result", m0_rsp_result, 32'h1234_0000);
    set_m0(1'b0, 12'h0, 32'h0, 32'h0);
    cycle("idle2");

    // Reset mid-stream with both responses held
    m0_rsp_ready = 1'b0; m1_rsp_ready = 1'b0;
    set_m0(1'b1, 12'h040, 32'h0000_00F0, 32'h0000_000F);
    set_m1(1'b1, 12'h800, 32'h0, 32'h0000_ABCD);
    for (int k = 0; k < 3; k++) cycle($sformatf("fill%0d", k));
    chk("fill_m0_held", {31'b0, m0_rsp_valid}, 32'd1);
    chk("fill_m1_held", {31'b0, m1_rsp_valid}, 32'd1);
    do_reset("rst2");
    m0_rsp_ready = 1'b1; m1_rsp_ready = 1'b1;
    #1;
    chk("postrst_m0_gnt", {31'b0, m0_req_ready}, 32'd1);
    chk("postrst_m1_gnt", {31'b0, m1_req_ready}, 32'd0);
    cycle("postrst");

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      set_m0($urandom_range(0, 9) < 7, rnd_op(), rnd_data(), rnd_data());
      set_m1($urandom_range(0, 9) < 7, rnd_op(), rnd_data(), rnd_data());
      m0_rsp_ready = $urandom_range(0, 9) < 6;
      m1_rsp_ready = $urandom_range(0, 9) < 6;
      cycle($sformatf("rnd%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter RR_EN, default 1, where 1 selects round-robin arbitration and 0 selects fixed priority to master 0.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports m0_req_valid / m1_req_valid  input  1  request present.
REQ-005 SHALL have ports m0_req_ready / m1_req_ready  output  1  request accepted this cycle when valid is also high.
REQ-006 SHALL have ports m0_req_op / m1_req_op  input  12  one-hot ALU op: bit0 add, 1 sub, 2 slt, 3 sltu, 4 and, 5 nor, 6 or, 7 xor, 8 sll, 9 srl, 10 sra, 11 lui.
REQ-007 SHALL have ports m0_req_src1, m0_req_src2, m1_req_src1, m1_req_src2  input  32  operands (src1[4:0] is the shift amount for shifts).
REQ-008 SHALL have ports m0_rsp_valid / m1_rsp_valid  output  1  response held.
REQ-009 SHALL have ports m0_rsp_ready / m1_rsp_ready  input  1  consumer takes response.
REQ-010 SHALL have ports m0_rsp_result / m1_rsp_result  output  32  ALU result.
REQ-011 SHALL have ports m0_rsp_overflow / m1_rsp_overflow  output  1  signed overflow of add/sub.

Function
REQ-012 SHALL share exactly one ALU instance, issuing at most one operation per cycle.
REQ-013 SHALL hold one response register per master; master i is eligible only if its register is empty or drained this cycle (rsp_valid & rsp_ready).
REQ-014 SHALL assert mi_req_ready combinationally only for the granted, eligible master; req_ready SHALL NOT depend on req_valid of the same master.
REQ-015 SHALL, with RR_EN=1 and both eligible and valid, grant the master not granted last; a single eligible valid master SHALL be granted immediately.
REQ-016 SHALL, with RR_EN=0, always grant master 0 when it is valid and eligible.
REQ-017 SHALL update the last-grant pointer only on an accepted transfer.
REQ-018 SHALL have latency 1: transfer accepted at edge N -> rsp_valid, result, overflow visible after edge N, stable until rsp_ready seen high.
REQ-019 SHALL pass the ALU result unmodified: add/sub wrap modulo 2^32; slt/sltu return 0 or 1; lui returns src2[15:0]<<16; srl/sra shift src2 by src1[4:0].
REQ-020 SHALL set overflow only for add/sub signed overflow; 0 for all other ops.
REQ-021 SHALL produce result 0 and overflow 0 for op = 0; multi-hot ops SHALL yield the OR of the selected results (no error flag).
REQ-022 SHALL support back-to-back acceptance for one master every cycle while its rsp_ready is held high.
REQ-023 SHALL leave a stalled master's response untouched while the other master continues issuing.

Reset
REQ-024 SHALL on reset clear m0/m1_rsp_valid, rsp_result, rsp_overflow to 0 immediately, without waiting for clk.
REQ-025 SHALL on reset set the last-grant pointer to master 1, so master 0 wins the first contention.
REQ-026 SHALL drive both req_ready low while reset is high; in-flight operations are discarded.

Structure
REQ-027 SHALL take op bit indices (ADD=0 .. LUI=11), ALU_OP_W=12, DATA_W=32 and master count from shared package alu_pkg.
REQ-028 SHALL instantiate the existing alu module as its only sub-module; arbitration and response registers stay in alu_arbiter.

Verification
REQ-029 SHALL cover: m0 add 7+5 -> m0_rsp_result 12, overflow 0, one cycle after acceptance.
REQ-030 SHALL cover: m1 add 0x7FFFFFFF+1 -> 0x80000000, overflow 1; m1 sra src2 0x80000000, src1 4 -> 0xF8000000, overflow 0.
REQ-031 SHALL cover: both valid every cycle after reset, rsp_ready high -> grants m0,m1,m0,m1; with RR_EN=0 -> m0 every cycle.
REQ-032 SHALL cover: m0_rsp_valid=1, m0_rsp_ready=0 -> m0_req_ready 0, m1 served each cycle; raising m0_rsp_ready -> drain and new m0 accept in the same cycle.
REQ-033 SHALL cover: reset asserted mid-stream with both responses held -> both rsp_valid 0 before next clk edge, first post-reset contention granted to m0.
